// File: rtl/memory_controller.sv
// memory_controller: byte-serial arbiter between the unified 8-bit RAM port and the fetch/LSU requesters
`timescale 1ns/1ps
module memory_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BOUNDARY = 32'h0003_0000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  io_buffer_full_in,
  input  logic [7:0]            mem_din_in,
  output logic [7:0]            mem_dout_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_wr_out,
  input  logic                  enable_from_fetch,
  input  logic [ADDR_WIDTH-1:0] addr_from_fetch,
  output logic                  end_to_fetch,
  output logic [31:0]           data_to_fetch,
  input  logic                  enable_from_lsu,
  input  logic                  read_write_flag_from_lsu,
  input  logic [ADDR_WIDTH-1:0] address_from_lsu,
  input  logic [1:0]            size_from_lsu,
  input  logic [31:0]           data_from_lsu,
  output logic                  end_to_lsu,
  output logic [31:0]           data_to_lsu,
  output logic                  aviliable_to_lsu,
  input  logic                  rollback_flag_from_rob
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state;
  logic [2:0] cnt, n, lsu_n;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0] sdata, rbuf, rd_word;
  logic src_lsu, lsu_io_hold, lsu_ok, fetch_ok;
  logic [1:0] cap_idx;
  assign lsu_io_hold = !read_write_flag_from_lsu && address_from_lsu >= IO_BOUNDARY && io_buffer_full_in;
  assign lsu_ok = enable_from_lsu && !end_to_lsu && !lsu_io_hold;
  assign fetch_ok = enable_from_fetch && !end_to_fetch;
  assign lsu_n = size_from_lsu == 2'd0 ? 3'd1 : size_from_lsu == 2'd1 ? 3'd2 : 3'd4;
  assign cap_idx = 2'(cnt - 3'd2);
  assign rd_word = rbuf | (32'(mem_din_in) << {n - 3'd1, 3'b000});
  assign aviliable_to_lsu = state == IDLE;
  // accept requests, step the byte sequence, and produce the done pulses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      base <= '0;
      sdata <= '0;
      rbuf <= '0;
      src_lsu <= 1'b0;
      mem_dout_out <= '0;
      mem_a_out <= '0;
      mem_wr_out <= 1'b0;
      end_to_fetch <= 1'b0;
      data_to_fetch <= '0;
      end_to_lsu <= 1'b0;
      data_to_lsu <= '0;
    end else if (rdy_in) begin
      end_to_fetch <= 1'b0;
      end_to_lsu <= 1'b0;
      case (state)
        IDLE: if (!rollback_flag_from_rob) begin
          if (lsu_ok) begin
            base <= address_from_lsu;
            mem_a_out <= address_from_lsu;
            src_lsu <= 1'b1;
            n <= lsu_n;
            cnt <= 3'd1;
            rbuf <= '0;
            if (read_write_flag_from_lsu) state <= READ;
            else begin
              state <= WRITE;
              mem_wr_out <= 1'b1;
              mem_dout_out <= data_from_lsu[7:0];
              sdata <= data_from_lsu >> 8;
            end
          end else if (fetch_ok) begin
            base <= addr_from_fetch;
            mem_a_out <= addr_from_fetch;
            src_lsu <= 1'b0;
            n <= 3'd4;
            cnt <= 3'd1;
            rbuf <= '0;
            state <= READ;
          end
        end
        READ: if (rollback_flag_from_rob) begin
          state <= IDLE;
          mem_a_out <= '0;
        end else begin
          cnt <= cnt + 3'd1;
          if (cnt < n) mem_a_out <= base + ADDR_WIDTH'(cnt);
          if (cnt == n + 3'd1) begin
            if (src_lsu) begin
              data_to_lsu <= rd_word;
              end_to_lsu <= 1'b1;
            end else begin
              data_to_fetch <= rd_word;
              end_to_fetch <= 1'b1;
            end
            mem_a_out <= '0;
            state <= IDLE;
          end else if (cnt >= 3'd2) rbuf[{cap_idx, 3'b000} +: 8] <= mem_din_in;
        end
        WRITE: begin
          cnt <= cnt + 3'd1;
          if (cnt == n) begin
            mem_wr_out <= 1'b0;
            mem_a_out <= '0;
            end_to_lsu <= 1'b1;
            state <= IDLE;
          end else begin
            mem_a_out <= base + ADDR_WIDTH'(cnt);
            mem_dout_out <= sdata[7:0];
            sdata <= sdata >> 8;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: randomized and directed checks of memory_controller against a byte-array model
`timescale 1ns/1ps
module tb_memory_controller;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic io_buffer_full_in = 1'b0;
  logic [7:0] mem_din_in = '0;
  logic [7:0] mem_dout_out;
  logic [31:0] mem_a_out;
  logic mem_wr_out;
  logic enable_from_fetch = 1'b0;
  logic [31:0] addr_from_fetch = '0;
  logic end_to_fetch;
  logic [31:0] data_to_fetch;
  logic enable_from_lsu = 1'b0;
  logic read_write_flag_from_lsu = 1'b0;
  logic [31:0] address_from_lsu = '0;
  logic [1:0] size_from_lsu = '0;
  logic [31:0] data_from_lsu = '0;
  logic end_to_lsu;
  logic [31:0] data_to_lsu;
  logic aviliable_to_lsu;
  logic rollback_flag_from_rob = 1'b0;

  int total = 0;
  int bad = 0;
  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  typedef struct packed {logic [31:0] a; logic [7:0] d;} wr_t;
  wr_t wr_q[$];
  logic [31:0] addr_q[$];

  memory_controller dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full_in(io_buffer_full_in),
    .mem_din_in(mem_din_in), .mem_dout_out(mem_dout_out), .mem_a_out(mem_a_out), .mem_wr_out(mem_wr_out),
    .enable_from_fetch(enable_from_fetch), .addr_from_fetch(addr_from_fetch),
    .end_to_fetch(end_to_fetch), .data_to_fetch(data_to_fetch),
    .enable_from_lsu(enable_from_lsu), .read_write_flag_from_lsu(read_write_flag_from_lsu),
    .address_from_lsu(address_from_lsu), .size_from_lsu(size_from_lsu), .data_from_lsu(data_from_lsu),
    .end_to_lsu(end_to_lsu), .data_to_lsu(data_to_lsu), .aviliable_to_lsu(aviliable_to_lsu),
    .rollback_flag_from_rob(rollback_flag_from_rob)
  );

  always #5 clk_in = ~clk_in;

  // RAM with one-edge read latency, plus a log of every committed write
  always @(posedge clk_in) begin
    if (rst_in && rdy_in && mem_wr_out) wr_q.push_back({mem_a_out, mem_dout_out});
    if (mem_wr_out) ram[mem_a_out] = mem_dout_out;
    mem_din_in <= ram.exists(mem_a_out) ? ram[mem_a_out] : 8'h00;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + i);
    return v;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  task automatic put(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int j = 0; j < n; j++) ref_mem[a + j] = d[8*j +: 8];
  endtask

  function automatic bit writes_ok(input logic [31:0] a, input logic [31:0] d, input int n);
    if (wr_q.size() != n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (wr_q[i].a !== a + i || wr_q[i].d !== d[8*i +: 8]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit addrs_ok(input logic [31:0] a, input int n);
    if (addr_q.size() < n) return 1'b0;
    for (int i = 0; i < n; i++) if (addr_q[i] !== a + i) return 1'b0;
    return 1'b1;
  endfunction

  // issue one request with the controller idle; lat counts edges from accept to the done pulse
  task automatic run_req(input bit lsu, input bit rd, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] d, output logic [31:0] got, output int lat, output logic end_after);
    got = '0;
    lat = -1;
    addr_q.delete();
    if (lsu) begin
      read_write_flag_from_lsu = rd;
      address_from_lsu = a;
      size_from_lsu = sz;
      data_from_lsu = d;
      enable_from_lsu = 1'b1;
    end else begin
      addr_from_fetch = a;
      enable_from_fetch = 1'b1;
    end
    for (int t = 0; t < 20; t++) begin
      tick();
      if (lsu ? end_to_lsu : end_to_fetch) begin
        lat = t;
        got = lsu ? data_to_lsu : data_to_fetch;
        break;
      end
      addr_q.push_back(mem_a_out);
    end
    enable_from_lsu = 1'b0;
    enable_from_fetch = 1'b0;
    tick();
    end_after = lsu ? end_to_lsu : end_to_fetch;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    total++;
    if ({mem_a_out, mem_dout_out, mem_wr_out, end_to_fetch, end_to_lsu} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got a=%h dout=%h wr=%b ef=%b el=%b exp zeros", mem_a_out, mem_dout_out, mem_wr_out, end_to_fetch, end_to_lsu);
    end
    total++;
    if ({data_to_fetch, data_to_lsu} !== '0) begin
      bad++;
      $display("FAIL reset_data: got f=%h l=%h exp 0", data_to_fetch, data_to_lsu);
    end
    total++;
    if (aviliable_to_lsu !== 1'b1) begin
      bad++;
      $display("FAIL reset_avail: got=%b exp=1", aviliable_to_lsu);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
    total++;
    if (aviliable_to_lsu !== 1'b1 || mem_a_out !== '0) begin
      bad++;
      $display("FAIL post_reset_idle: got avail=%b a=%h exp 1/0", aviliable_to_lsu, mem_a_out);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] got;
    int lat;
    logic ea;
    put(32'h1000, 8'h13);
    put(32'h1001, 8'h05);
    put(32'h1002, 8'h10);
    put(32'h1003, 8'h00);
    run_req(1'b0, 1'b1, 32'h1000, 2'd2, '0, got, lat, ea);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL fetch_lat: got=%0d exp=5", lat); end
    total++;
    if (got !== 32'h0010_0513) begin bad++; $display("FAIL fetch_data: got=%h exp=00100513", got); end
    total++;
    if (!addrs_ok(32'h1000, 4)) begin bad++; $display("FAIL fetch_addr_seq: got=%p exp=1000..1003", addr_q); end
    total++;
    if (ea !== 1'b0) begin bad++; $display("FAIL fetch_pulse_width: got=%b exp=0", ea); end
  endtask

  task automatic test_store_word();
    logic [31:0] got;
    int lat;
    logic ea;
    wr_q.delete();
    run_req(1'b1, 1'b0, 32'h2000, 2'd2, 32'hDEAD_BEEF, got, lat, ea);
    ref_store(32'h2000, 32'hDEAD_BEEF, 4);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL sw_lat: got=%0d exp=4", lat); end
    total++;
    if (!writes_ok(32'h2000, 32'hDEAD_BEEF, 4)) begin bad++; $display("FAIL sw_bytes: got=%p exp=EF,BE,AD,DE@2000", wr_q); end
    total++;
    if ({ram[32'h2003], ram[32'h2002], ram[32'h2001], ram[32'h2000]} !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL sw_ram: got=%h%h%h%h exp=deadbeef", ram[32'h2003], ram[32'h2002], ram[32'h2001], ram[32'h2000]);
    end
    total++;
    if (ea !== 1'b0) begin bad++; $display("FAIL sw_pulse_width: got=%b exp=0", ea); end
  endtask

  task automatic test_priority();
    int lat;
    logic seen_f;
    lat = -1;
    seen_f = 1'b0;
    addr_from_fetch = 32'h1000;
    enable_from_fetch = 1'b1;
    read_write_flag_from_lsu = 1'b1;
    address_from_lsu = 32'h2002;
    size_from_lsu = 2'd0;
    enable_from_lsu = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      seen_f |= end_to_fetch;
      if (end_to_lsu) begin lat = t; break; end
    end
    enable_from_lsu = 1'b0;
    total++;
    if (lat !== 2 || data_to_lsu !== 32'h0000_00AD) begin
      bad++;
      $display("FAIL prio_lsu_first: got lat=%0d d=%h exp 2/000000ad", lat, data_to_lsu);
    end
    total++;
    if (seen_f !== 1'b0) begin bad++; $display("FAIL prio_fetch_early: got=%b exp=0", seen_f); end
    tick();
    total++;
    if (mem_a_out !== 32'h1000 || aviliable_to_lsu !== 1'b0) begin
      bad++;
      $display("FAIL prio_fetch_accept: got a=%h avail=%b exp 1000/0", mem_a_out, aviliable_to_lsu);
    end
    lat = -1;
    for (int t = 1; t < 20; t++) begin
      tick();
      if (end_to_fetch) begin lat = t; break; end
    end
    enable_from_fetch = 1'b0;
    total++;
    if (lat !== 5 || data_to_fetch !== 32'h0010_0513) begin
      bad++;
      $display("FAIL prio_fetch_done: got lat=%0d d=%h exp 5/00100513", lat, data_to_fetch);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    lat = -1;
    read_write_flag_from_lsu = 1'b1;
    address_from_lsu = 32'h2000;
    size_from_lsu = 2'd0;
    enable_from_lsu = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (end_to_lsu) begin lat = t; break; end
    end
    total++;
    if (lat !== 2 || data_to_lsu !== 32'h0000_00EF) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d d=%h exp 2/000000ef", lat, data_to_lsu);
    end
    address_from_lsu = 32'h2001;
    tick();
    total++;
    if (aviliable_to_lsu !== 1'b1 || mem_a_out !== '0) begin
      bad++;
      $display("FAIL b2b_no_accept_on_end: got avail=%b a=%h exp 1/0", aviliable_to_lsu, mem_a_out);
    end
    tick();
    total++;
    if (aviliable_to_lsu !== 1'b0 || mem_a_out !== 32'h2001) begin
      bad++;
      $display("FAIL b2b_accept: got avail=%b a=%h exp 0/2001", aviliable_to_lsu, mem_a_out);
    end
    lat = -1;
    for (int t = 1; t < 20; t++) begin
      tick();
      if (end_to_lsu) begin lat = t; break; end
    end
    enable_from_lsu = 1'b0;
    total++;
    if (lat !== 2 || data_to_lsu !== 32'h0000_00BE) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d d=%h exp 2/000000be", lat, data_to_lsu);
    end
    tick();
  endtask

  task automatic test_io_hold();
    logic [31:0] got;
    int lat;
    logic ea;
    wr_q.delete();
    io_buffer_full_in = 1'b1;
    read_write_flag_from_lsu = 1'b0;
    address_from_lsu = 32'h0003_0000;
    size_from_lsu = 2'd0;
    data_from_lsu = 32'h1234_565A;
    enable_from_lsu = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (mem_wr_out !== 1'b0 || end_to_lsu !== 1'b0 || aviliable_to_lsu !== 1'b1) begin
        bad++;
        $display("FAIL io_held_%0d: got wr=%b end=%b avail=%b exp 0/0/1", i, mem_wr_out, end_to_lsu, aviliable_to_lsu);
      end
    end
    io_buffer_full_in = 1'b0;
    tick();
    total++;
    if (mem_wr_out !== 1'b1 || mem_a_out !== 32'h0003_0000 || mem_dout_out !== 8'h5A) begin
      bad++;
      $display("FAIL io_accept: got wr=%b a=%h d=%h exp 1/00030000/5a", mem_wr_out, mem_a_out, mem_dout_out);
    end
    tick();
    enable_from_lsu = 1'b0;
    total++;
    if (end_to_lsu !== 1'b1 || mem_wr_out !== 1'b0) begin
      bad++;
      $display("FAIL io_end: got end=%b wr=%b exp 1/0", end_to_lsu, mem_wr_out);
    end
    tick();
    ref_store(32'h0003_0000, 32'h5A, 1);
    total++;
    if (!writes_ok(32'h0003_0000, 32'h5A, 1)) begin bad++; $display("FAIL io_single_write: got=%p exp one 5a@30000", wr_q); end
    io_buffer_full_in = 1'b1;
    run_req(1'b1, 1'b1, 32'h0003_0000, 2'd0, '0, got, lat, ea);
    total++;
    if (lat !== 2 || got !== 32'h5A) begin bad++; $display("FAIL io_read_not_held: got lat=%0d d=%h exp 2/5a", lat, got); end
    wr_q.delete();
    run_req(1'b1, 1'b0, 32'h0002_FFFF, 2'd0, 32'h77, got, lat, ea);
    ref_store(32'h0002_FFFF, 32'h77, 1);
    io_buffer_full_in = 1'b0;
    total++;
    if (lat !== 1 || !writes_ok(32'h0002_FFFF, 32'h77, 1)) begin
      bad++;
      $display("FAIL below_io_write: got lat=%0d log=%p exp 1/77@2ffff", lat, wr_q);
    end
  endtask

  task automatic test_rollback();
    logic [31:0] got, d;
    int lat;
    logic ea, seen;
    for (int i = 0; i < 4; i++) put(32'h5000 + i, 8'($urandom));
    addr_from_fetch = 32'h5000;
    enable_from_fetch = 1'b1;
    repeat (3) tick();
    rollback_flag_from_rob = 1'b1;
    enable_from_fetch = 1'b0;
    tick();
    rollback_flag_from_rob = 1'b0;
    total++;
    if (end_to_fetch !== 1'b0 || aviliable_to_lsu !== 1'b1 || mem_a_out !== '0) begin
      bad++;
      $display("FAIL rb_fetch_abort: got end=%b avail=%b a=%h exp 0/1/0", end_to_fetch, aviliable_to_lsu, mem_a_out);
    end
    seen = 1'b0;
    repeat (4) begin tick(); seen |= end_to_fetch; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rb_fetch_no_end: got=%b exp=0", seen); end
    read_write_flag_from_lsu = 1'b1;
    address_from_lsu = 32'h5001;
    size_from_lsu = 2'd0;
    enable_from_lsu = 1'b1;
    repeat (2) tick();
    rollback_flag_from_rob = 1'b1;
    enable_from_lsu = 1'b0;
    tick();
    total++;
    if (end_to_lsu !== 1'b0 || aviliable_to_lsu !== 1'b1) begin
      bad++;
      $display("FAIL rb_on_end_edge: got end=%b avail=%b exp 0/1", end_to_lsu, aviliable_to_lsu);
    end
    enable_from_lsu = 1'b1;
    tick();
    total++;
    if (aviliable_to_lsu !== 1'b1 || mem_a_out !== '0) begin
      bad++;
      $display("FAIL rb_blocks_accept: got avail=%b a=%h exp 1/0", aviliable_to_lsu, mem_a_out);
    end
    rollback_flag_from_rob = 1'b0;
    enable_from_lsu = 1'b0;
    run_req(1'b1, 1'b1, 32'h5001, 2'd0, '0, got, lat, ea);
    total++;
    if (lat !== 2 || got !== ref_load(32'h5001, 1)) begin
      bad++;
      $display("FAIL rb_after_read: got lat=%0d d=%h exp 2/%h", lat, got, ref_load(32'h5001, 1));
    end
    d = $urandom;
    wr_q.delete();
    read_write_flag_from_lsu = 1'b0;
    address_from_lsu = 32'h6000;
    size_from_lsu = 2'd2;
    data_from_lsu = d;
    enable_from_lsu = 1'b1;
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (end_to_lsu) begin lat = t; break; end
      if (t == 1) rollback_flag_from_rob = 1'b1;
    end
    rollback_flag_from_rob = 1'b0;
    enable_from_lsu = 1'b0;
    tick();
    ref_store(32'h6000, d, 4);
    total++;
    if (lat !== 4 || !writes_ok(32'h6000, d, 4)) begin
      bad++;
      $display("FAIL rb_sw_completes: got lat=%0d log=%p exp 4/%h@6000", lat, wr_q, d);
    end
  endtask

  task automatic test_stall_and_reset();
    int lat;
    logic [31:0] got;
    lat = -1;
    got = '0;
    addr_from_fetch = 32'h1000;
    enable_from_fetch = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (end_to_fetch) begin lat = t; got = data_to_fetch; break; end
      if (t == 4) rdy_in = 1'b0;
      if (t == 6) rdy_in = 1'b1;
    end
    rdy_in = 1'b1;
    enable_from_fetch = 1'b0;
    tick();
    total++;
    if (lat !== 7 || got !== 32'h0010_0513) begin
      bad++;
      $display("FAIL rdy_stall: got lat=%0d d=%h exp 7/00100513", lat, got);
    end
    enable_from_fetch = 1'b1;
    repeat (2) tick();
    #2;
    rst_in = 1'b0;
    #1;
    total++;
    if ({mem_a_out, mem_dout_out, mem_wr_out, end_to_fetch, end_to_lsu, data_to_fetch, data_to_lsu} !== '0 || aviliable_to_lsu !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got a=%h df=%h avail=%b exp 0/0/1", mem_a_out, data_to_fetch, aviliable_to_lsu);
    end
    enable_from_fetch = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] got, a, d, exp;
    logic [1:0] sz;
    int lat, op, n;
    logic ea;
    for (int i = 0; i < 64; i++) put(32'h4000 + i, 8'($urandom));
    for (int i = 0; i < 8; i++) put(32'hFFFF_FFFC + i, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 6) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : 32'h4000 + $urandom_range(0, 59);
      d = $urandom;
      n = op == 0 ? 4 : nbytes(sz);
      exp = ref_load(a, n);
      wr_q.delete();
      run_req(op != 0, op != 2, a, op == 0 ? 2'd2 : sz, d, got, lat, ea);
      total++;
      if (lat !== (op == 2 ? n : n + 1)) begin
        bad++;
        $display("FAIL rand_lat: op=%0d a=%h n=%0d got=%0d exp=%0d", op, a, n, lat, op == 2 ? n : n + 1);
      end
      if (op == 2) begin
        total++;
        if (!writes_ok(a, d, n)) begin bad++; $display("FAIL rand_store: a=%h n=%0d got=%p exp data %h", a, n, wr_q, d); end
        ref_store(a, d, n);
      end else begin
        total++;
        if (got !== exp) begin bad++; $display("FAIL rand_load: op=%0d a=%h n=%0d got=%h exp=%h", op, a, n, got, exp); end
        total++;
        if (!addrs_ok(a, n)) begin bad++; $display("FAIL rand_addr_seq: a=%h n=%0d got=%p", a, n, addr_q); end
      end
      total++;
      if (ea !== 1'b0) begin bad++; $display("FAIL rand_pulse_width: op=%0d got=%b exp=0", op, ea); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_word();
    test_priority();
    test_back_to_back();
    test_io_hold();
    test_rollback();
    test_stall_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
